mac_nxn: RTL and testbench
==========================

// Module: mac_nxn
// PURPOSE
//  Parametrised NxN output-stationary systolic MAC tile with wide internal accumulators.
//  Computes one BLOCK_SIZE x BLOCK_SIZE tile C = A(NxK) * B(KxN) over K = INNER_DIMENSION beats.
//  Streams A rows (west) and B columns (north) through valid/ready input and output handshakes.
//  Optionally accumulates partial sums across consecutive tiles.
//  Sits between the matrix tile scheduler and the output writeback in matrix_mult.
// PARAMETERS
//  WIDTH            16  signed fixed-point operand/result width
//  FRAC_WIDTH       8   fractional bits of operands and results
//  BLOCK_SIZE       2   array dimension N (N x N PEs), >= 1
//  INNER_DIMENSION  64  beats per tile (K), >= 1
//  ACC_WIDTH        40  PE accumulator width; must be >= 2*WIDTH
//  SATURATE         1   1: saturate result to WIDTH; 0: truncate (wrap)
// PORTS
//  clk        input   1                    clock, rising edge
//  rst        input   1                    asynchronous, active-high reset
//  in_valid   input   1                    beat present on in_west/in_north
//  in_ready   output  1                    block accepts a beat this cycle
//  in_west    input   BLOCK_SIZE*WIDTH     lane i = A[i][k]; lane 0 in LSBs
//  in_north   input   BLOCK_SIZE*WIDTH     lane j = B[k][j]; lane 0 in LSBs
//  acc_keep   input   1                    sampled at out handshake: 1 = keep accumulators
//  out_valid  output  1                    tile result available
//  out_ready  input   1                    consumer takes result
//  out        output  BLOCK_SIZE^2*WIDTH   C[i][j] at index i*N+j; index 0 in LSBs
//  overflow   output  1                    any element of current out saturated/wrapped
//  busy       output  1                    state != IDLE
// BEHAVIOUR
//  - Reset (async, any state): state IDLE; all PE regs, skew regs and counters = 0.
//    Outputs while rst is high: out = 0, out_valid = 0, overflow = 0, busy = 0, in_ready = 0.
//    in_ready = 1 from the first cycle after rst is released.
//  - FSM transitions:
//    IDLE   -> STREAM   on the first accepted beat
//    STREAM -> DRAIN    after beat K-1 is accepted
//    DRAIN  -> OUT      after 2*N-1 cycles
//    OUT    -> IDLE     on out_valid && out_ready
//  - in_ready = 1 only in IDLE, and in STREAM while beat count < K. Accept = in_valid && in_ready.
//  - Array advances only on accept or in DRAIN. A bubble (in_valid = 0 in STREAM) freezes
//    every skew reg, PE pipe reg and accumulator, so results are independent of bubbles.
//  - Skew: west lane i and north lane j are delayed i and j advance-steps respectively.
//    DRAIN injects zeros on all lanes.
//  - PE(i,j): acc += a*b. The product is the full 2*WIDTH signed value, sign-extended to ACC_WIDTH.
//    Accumulation wraps at ACC_WIDTH (no internal saturation). a is passed east, b passed south.
//  - Result per element: r = (acc + 2^(FRAC_WIDTH-1)) >>> FRAC_WIDTH (round half up, arithmetic).
//    SATURATE = 1: clamp r to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; clamping sets overflow.
//    SATURATE = 0: out = r[WIDTH-1:0]; overflow set if r does not fit in WIDTH.
//  - out/overflow are registered on DRAIN -> OUT. out_valid rises exactly 2*N cycles after the
//    edge accepting beat K-1 (N = 2: 4 cycles).
//  - out/overflow/out_valid are held stable while out_valid && !out_ready.
//    in_ready = 0 in DRAIN and OUT.
//  - At out handshake: out_valid -> 0.
//    acc_keep = 0: all accumulators cleared on the same edge.
//    acc_keep = 1: accumulators retained, so the next tile adds onto them.
//  - K = 1: STREAM is a single beat; IDLE accepting it goes straight to DRAIN.
//  - Reset mid-tile discards the partial tile entirely; no output is produced for it.
// STRUCTURE
//  - mac_pkg: FSM state enum (IDLE, STREAM, DRAIN, OUT); clog2 function; function
//    round_sat(acc, frac, width, saturate) returning {ovf, result}.
//  - Sub-module mac_pe: one PE with a/b pipe regs, signed multiply, ACC_WIDTH accumulator,
//    advance and clear inputs. Instantiated NxN via generate.
//  - Top holds the FSM, beat/drain counters, skew shift registers and the output register bank.
// TESTING
//  1. N=2, K=4, A = B = all 0x0100 (1.0), continuous valid
//     -> every out element = 0x0400; out_valid exactly 4 cycles after beat 3; overflow = 0.
//  2. Same data with in_valid toggling every other cycle -> identical out and latency from beat 3.
//  3. out_ready held low 10 cycles -> out stable, in_ready = 0;
//     out_ready = 1 -> out_valid drops, in_ready = 1 next cycle.
//  4. A = B = all 0x7FFF, K=4: SATURATE=1 -> all out = 0x7FFF, overflow = 1;
//     SATURATE=0 -> out = truncated r bits, overflow = 1.
//  5. Tile of ones with acc_keep = 1 at handshake, then a second identical tile
//     -> second result 0x0800; a third after acc_keep = 0 -> 0x0400.
//  6. rst pulsed after 2 beats of a tile -> out_valid = 0, in_ready = 1 after release;
//     a fresh tile of ones -> 0x0400 (no residue).
//  Also: N=3, K=5 random signed operands vs reference model (rounding, negatives), bit-exact.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the NxN systolic MAC tile.
// Holds the control FSM encoding, a constant-width log2 helper and the result
// rounding/saturation function used on every accumulator before it leaves the tile.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        OUT    = 2'd3
    } state_t;

    // Ceiling log2, intended for elaboration-time counter sizing.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Round half up at bit 'frac', then clamp (saturate=1) or keep the raw value.
    // Returns {ovf, result}; result is sign-extended to 64 bits, caller keeps the low 'width' bits.
    function automatic logic [64:0] round_sat(input logic signed [63:0] acc,
                                              input int                 frac,
                                              input int                 width,
                                              input logic               saturate);
        logic signed [63:0] rnd;
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        logic               ovf;
        rnd = (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
        r   = (acc + rnd) >>> frac;
        hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (width - 1));
        ovf = (r > hi) || (r < lo);
        if (saturate && (r > hi)) begin
            res = hi;
        end else if (saturate && (r < lo)) begin
            res = lo;
        end else begin
            res = r;
        end
        return {ovf, res};
    endfunction

endpackage

// File: rtl/mac_pe.sv
// Single processing element: multiply the incoming a/b pair and accumulate.
// Latency: a/b forwarded east/south one advance-step later; acc updated on the same step.
// Backpressure: state only moves when adv_i is high; clr_i wipes the accumulator.
module mac_pe
    import mac_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        adv_i,
    input  logic                        clr_i,
    input  logic signed [WIDTH-1:0]     a_i,
    input  logic signed [WIDTH-1:0]     b_i,
    output logic signed [WIDTH-1:0]     a_o,
    output logic signed [WIDTH-1:0]     b_o,
    output logic signed [ACC_WIDTH-1:0] acc_o
);

    logic signed [WIDTH-1:0]     a_q;
    logic signed [WIDTH-1:0]     b_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [2*WIDTH-1:0]   prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;

    // Full-precision signed product, sign-extended into the accumulator width.
    assign prod     = a_i * b_i;
    assign prod_ext = ACC_WIDTH'(prod);

    // Pipe registers pass operands on; accumulator wraps at ACC_WIDTH, clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            if (adv_i) begin
                a_q <= a_i;
                b_q <= b_i;
            end
            if (clr_i) begin
                acc_q <= '0;
            end else if (adv_i) begin
                acc_q <= acc_q + prod_ext;
            end
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/mac_nxn.sv
// Output-stationary NxN systolic MAC tile computing C = A(NxK) * B(KxN).
// Latency: out_valid rises 2*N cycles after the edge accepting the last beat.
// Backpressure: in_ready only in IDLE/STREAM; result held in OUT until out_ready.
module mac_nxn
    import mac_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int FRAC_WIDTH      = 8,
    parameter int BLOCK_SIZE      = 2,
    parameter int INNER_DIMENSION = 64,
    parameter int ACC_WIDTH       = 40,
    parameter int SATURATE        = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [BLOCK_SIZE*WIDTH-1:0]            in_west,
    input  logic [BLOCK_SIZE*WIDTH-1:0]            in_north,
    input  logic                                   acc_keep,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [BLOCK_SIZE*BLOCK_SIZE*WIDTH-1:0] out,
    output logic                                   overflow,
    output logic                                   busy
);

    localparam int N  = BLOCK_SIZE;
    localparam int K  = INNER_DIMENSION;
    localparam int BW = clog2(K + 1);
    localparam int DW = clog2(2 * N);

    state_t                      state_q, state_d;
    logic [BW-1:0]               beat_cnt_q;
    logic [DW-1:0]               drain_cnt_q;
    logic [N*N*WIDTH-1:0]        out_q, res_d;
    logic                        ovf_q, ovf_d;
    logic                        accept, adv, last_beat, drain_done, clr;

    logic signed [WIDTH-1:0]     west_sk  [N];
    logic signed [WIDTH-1:0]     north_sk [N];
    logic signed [WIDTH-1:0]     a_pass   [N][N];
    logic signed [WIDTH-1:0]     b_pass   [N][N];
    logic signed [ACC_WIDTH-1:0] acc_w    [N*N];

    assign accept     = in_valid && in_ready;
    assign adv        = accept || (state_q == DRAIN);
    assign last_beat  = accept && (beat_cnt_q == BW'(K - 1));
    assign drain_done = (state_q == DRAIN) && (drain_cnt_q == DW'(2 * N - 1));
    assign clr        = out_valid && out_ready && !acc_keep;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: stream K beats, flush the array, then hold the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = last_beat ? DRAIN : STREAM;
            STREAM:  if (last_beat) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs; in_ready is forced low while reset is asserted.
    always_comb begin
        in_ready  = !rst && ((state_q == IDLE) ||
                             ((state_q == STREAM) && (beat_cnt_q < BW'(K))));
        out_valid = (state_q == OUT);
        busy      = (state_q != IDLE);
    end

    // Beat counter wraps after the last beat; drain counter only runs in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            if (accept) begin
                beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 1'b1;
            end
            if (state_q == DRAIN) begin
                drain_cnt_q <= drain_done ? '0 : drain_cnt_q + 1'b1;
            end else begin
                drain_cnt_q <= '0;
            end
        end
    end

    // Input skew: lane l is delayed l advance-steps so operands meet on the diagonal.
    for (genvar l = 0; l < N; l++) begin : g_skew
        logic signed [WIDTH-1:0] w_in, n_in;
        assign w_in = (state_q == DRAIN) ? '0 : in_west[l*WIDTH +: WIDTH];
        assign n_in = (state_q == DRAIN) ? '0 : in_north[l*WIDTH +: WIDTH];
        if (l == 0) begin : g_direct
            assign west_sk[l]  = w_in;
            assign north_sk[l] = n_in;
        end else begin : g_delay
            logic signed [WIDTH-1:0] w_sr_q [l];
            logic signed [WIDTH-1:0] n_sr_q [l];
            // Shift only on an array advance so bubbles freeze the skew.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < l; s++) begin
                        w_sr_q[s] <= '0;
                        n_sr_q[s] <= '0;
                    end
                end else if (adv) begin
                    w_sr_q[0] <= w_in;
                    n_sr_q[0] <= n_in;
                    for (int s = 1; s < l; s++) begin
                        w_sr_q[s] <= w_sr_q[s-1];
                        n_sr_q[s] <= n_sr_q[s-1];
                    end
                end
            end
            assign west_sk[l]  = w_sr_q[l-1];
            assign north_sk[l] = n_sr_q[l-1];
        end
    end

    // PE grid: a flows east along a row, b flows south along a column.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [WIDTH-1:0] a_in, b_in;
            if (j == 0) begin : g_aw
                assign a_in = west_sk[i];
            end else begin : g_ap
                assign a_in = a_pass[i][j-1];
            end
            if (i == 0) begin : g_bn
                assign b_in = north_sk[j];
            end else begin : g_bp
                assign b_in = b_pass[i-1][j];
            end
            mac_pe #(
                .WIDTH     (WIDTH),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .adv_i (adv),
                .clr_i (clr),
                .a_i   (a_in),
                .b_i   (b_in),
                .a_o   (a_pass[i][j]),
                .b_o   (b_pass[i][j]),
                .acc_o (acc_w[i*N+j])
            );
        end
    end

    // Round/saturate every accumulator; overflow is the OR across elements.
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        for (int e = 0; e < N*N; e++) begin
            logic [64:0] rs;
            rs = round_sat(64'(acc_w[e]), FRAC_WIDTH, WIDTH, SATURATE != 0);
            res_d[e*WIDTH +: WIDTH] = rs[WIDTH-1:0];
            ovf_d = ovf_d | rs[64];
        end
    end

    // Result bank loads once on DRAIN -> OUT and is otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            ovf_q <= 1'b0;
        end else if (drain_done) begin
            out_q <= res_d;
            ovf_q <= ovf_d;
        end
    end

    assign out      = out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_mac_nxn.sv
// Bench for mac_nxn: a 2x2/K=4 saturating tile and a 3x3/K=5 wrapping tile.
// Drivers push expected tiles into scoreboards; per-DUT monitors pop on handshake.
// Reference: plain matrix products with floor-division rounding on 64-bit integers.
module tb_mac_nxn;

    typedef struct {
        logic [143:0] dat;
        logic         ovf;
        int           last_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 2x2, K=4, saturating
    logic        u2_in_valid, u2_in_ready, u2_acc_keep, u2_out_valid, u2_out_ready;
    logic        u2_overflow, u2_busy;
    logic [31:0] u2_in_west, u2_in_north;
    logic [63:0] u2_out;
    // 3x3, K=5, wrapping
    logic         u3_in_valid, u3_in_ready, u3_acc_keep, u3_out_valid, u3_out_ready;
    logic         u3_overflow, u3_busy;
    logic [47:0]  u3_in_west, u3_in_north;
    logic [143:0] u3_out;

    mac_nxn #(.WIDTH(16), .FRAC_WIDTH(8), .BLOCK_SIZE(2), .INNER_DIMENSION(4),
              .ACC_WIDTH(40), .SATURATE(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(u2_in_valid), .in_ready(u2_in_ready),
        .in_west(u2_in_west), .in_north(u2_in_north), .acc_keep(u2_acc_keep),
        .out_valid(u2_out_valid), .out_ready(u2_out_ready), .out(u2_out),
        .overflow(u2_overflow), .busy(u2_busy));

    mac_nxn #(.WIDTH(16), .FRAC_WIDTH(8), .BLOCK_SIZE(3), .INNER_DIMENSION(5),
              .ACC_WIDTH(40), .SATURATE(0)) dut3 (
        .clk(clk), .rst(rst), .in_valid(u3_in_valid), .in_ready(u3_in_ready),
        .in_west(u3_in_west), .in_north(u3_in_north), .acc_keep(u3_acc_keep),
        .out_valid(u3_out_valid), .out_ready(u3_out_ready), .out(u3_out),
        .overflow(u3_overflow), .busy(u3_busy));

    exp_t exp2_q[$];
    exp_t exp3_q[$];
    longint macc [2][9];
    logic signed [15:0] ta [3][5];
    logic signed [15:0] tb [5][3];

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    function automatic longint wrap40(input longint x);
        longint y;
        y = x & 64'h0000_00FF_FFFF_FFFF;
        if (y >= 64'sh0000_0080_0000_0000) y = y - 64'sh0000_0100_0000_0000;
        return y;
    endfunction

    // r = floor((acc + 128) / 256); clamp or keep low 16 bits.
    function automatic logic [16:0] model_elem(input longint acc, input bit sat);
        longint r;
        logic   ovf;
        r = acc + 128;
        if (r >= 0) r = r / 256;
        else        r = -((-r + 255) / 256);
        ovf = (r > 32767) || (r < -32768);
        if (sat && r > 32767)  r = 32767;
        if (sat && r < -32768) r = -32768;
        return {ovf, r[15:0]};
    endfunction

    task automatic model_tile(input int d, input int n, input int kk, input bit sat,
                              output logic [143:0] dat, output logic ovf);
        longint      s;
        logic [16:0] r;
        dat = '0;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < kk; k++) s += longint'(ta[i][k]) * longint'(tb[k][j]);
                macc[d][i*n+j] = wrap40(macc[d][i*n+j] + s);
                r = model_elem(macc[d][i*n+j], sat);
                dat[(i*n+j)*16 +: 16] = r[15:0];
                ovf = ovf | r[16];
            end
        end
    endtask

    function automatic logic [15:0] rnd_op(input int mode);
        int v;
        if (mode == 1) v = int'($urandom_range(1023)) - 512;
        else           v = int'($urandom);
        return 16'(v);
    endfunction

    // mode 0: constant v; 1: small signed; 2: full range
    task automatic fill(input int mode, input logic [15:0] v);
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 5; k++) begin
                ta[i][k] = (mode == 0) ? v : rnd_op(mode);
                tb[k][i] = (mode == 0) ? v : rnd_op(mode);
            end
        end
    endtask

    task automatic clear_model(input int d);
        for (int e = 0; e < 9; e++) macc[d][e] = 0;
    endtask

    // Entered and left at posedge+1.
    task automatic run2(input bit bubbles, input bit keep, input int hold);
        exp_t e;
        int   k = 0;
        int   guard = 0;
        bit   ph = 1'b0;
        model_tile(0, 2, 4, 1'b1, e.dat, e.ovf);
        e.last_edge = 0;
        u2_acc_keep  = keep;
        u2_out_ready = (hold == 0);
        while (k < 4 && guard < 200) begin
            u2_in_valid = !bubbles || ph;
            ph = !ph;
            for (int l = 0; l < 2; l++) begin
                u2_in_west[l*16 +: 16]  = ta[l][k];
                u2_in_north[l*16 +: 16] = tb[k][l];
            end
            @(negedge clk);
            if (u2_in_valid && u2_in_ready) begin
                if (k == 3) begin
                    e.last_edge = cyc + 1;
                    exp2_q.push_back(e);
                end
                k++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        u2_in_valid = 1'b0;
        if (k < 4) fail_now("run2 beats not accepted");
        if (hold > 0) begin
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!u2_out_valid && guard < 50);
            if (!u2_out_valid) fail_now("run2 out_valid timeout");
            for (int h = 0; h < hold; h++) begin
                chk("hold out", u2_out, e.dat);
                chk("hold out_valid", u2_out_valid, 1);
                chk("hold in_ready", u2_in_ready, 0);
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            u2_out_ready = 1'b1;
        end
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (u2_busy && guard < 100);
        if (u2_busy) fail_now("run2 idle timeout");
        chk("post-handshake out_valid", u2_out_valid, 0);
        chk("post-handshake in_ready", u2_in_ready, 1);
        if (!keep) clear_model(0);
        @(posedge clk);
        #1;
    endtask

    task automatic run3(input bit bubbles, input bit keep);
        exp_t e;
        int   k = 0;
        int   guard = 0;
        model_tile(1, 3, 5, 1'b0, e.dat, e.ovf);
        e.last_edge = 0;
        u3_acc_keep = keep;
        while (k < 5 && guard < 200) begin
            u3_in_valid  = !bubbles || ($urandom_range(3) != 0);
            u3_out_ready = $urandom_range(1);
            for (int l = 0; l < 3; l++) begin
                u3_in_west[l*16 +: 16]  = ta[l][k];
                u3_in_north[l*16 +: 16] = tb[k][l];
            end
            @(negedge clk);
            if (u3_in_valid && u3_in_ready) begin
                if (k == 4) exp3_q.push_back(e);
                k++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        u3_in_valid = 1'b0;
        if (k < 5) fail_now("run3 beats not accepted");
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (u3_busy) begin
                @(posedge clk);
                #1;
                u3_out_ready = $urandom_range(1);
            end
        end while (u3_busy && guard < 200);
        if (u3_busy) fail_now("run3 idle timeout");
        u3_out_ready = 1'b1;
        if (!keep) clear_model(1);
        @(posedge clk);
        #1;
    endtask

    // DUT2 monitor: latency on rising out_valid, data at handshake.
    bit prev2 = 1'b0;
    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst) begin
            prev2 = 1'b0;
        end else begin
            if (u2_out_valid && !prev2) begin
                if (exp2_q.size() > 0) chk("latency2", cyc - exp2_q[0].last_edge, 4);
                else fail_now("out_valid2 with nothing expected");
            end
            prev2 = u2_out_valid;
            if (u2_out_valid && u2_out_ready) begin
                if (exp2_q.size() == 0) begin
                    fail_now("out2 handshake with nothing expected");
                end else begin
                    e = exp2_q.pop_front();
                    chk("out2", u2_out, e.dat);
                    chk("overflow2", u2_overflow, e.ovf);
                end
            end
        end
    end

    // DUT3 monitor: data at handshake.
    always @(negedge clk) begin : mon3
        exp_t e;
        if (!rst && u3_out_valid && u3_out_ready) begin
            if (exp3_q.size() == 0) begin
                fail_now("out3 handshake with nothing expected");
            end else begin
                e = exp3_q.pop_front();
                chk("out3", u3_out, e.dat);
                chk("overflow3", u3_overflow, e.ovf);
            end
        end
    end

    initial begin
        int cnt;
        int guard;
        rst = 1'b1;
        u2_in_valid = 0; u2_in_west = '0; u2_in_north = '0; u2_acc_keep = 0; u2_out_ready = 1;
        u3_in_valid = 0; u3_in_west = '0; u3_in_north = '0; u3_acc_keep = 0; u3_out_ready = 1;
        clear_model(0);
        clear_model(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready2", u2_in_ready, 0);
        chk("reset out_valid2", u2_out_valid, 0);
        chk("reset busy2", u2_busy, 0);
        chk("reset overflow2", u2_overflow, 0);
        chk("reset out2", u2_out, 0);
        chk("reset in_ready3", u3_in_ready, 0);
        chk("reset out3", u3_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("release in_ready2", u2_in_ready, 1);
        chk("release in_ready3", u3_in_ready, 1);
        @(posedge clk);
        #1;

        // ones, continuous; with bubbles; with output stall
        fill(0, 16'h0100);
        run2(1'b0, 1'b0, 0);
        run2(1'b1, 1'b0, 0);
        run2(1'b0, 1'b0, 10);
        // saturation
        fill(0, 16'h7FFF);
        run2(1'b0, 1'b0, 0);
        // accumulate across tiles
        fill(0, 16'h0100);
        run2(1'b0, 1'b1, 0);
        run2(1'b0, 1'b0, 0);
        run2(1'b0, 1'b0, 0);

        // reset after two beats of a tile
        cnt = 0;
        guard = 0;
        while (cnt < 2 && guard < 50) begin
            u2_in_valid = 1'b1;
            for (int l = 0; l < 2; l++) begin
                u2_in_west[l*16 +: 16]  = ta[l][cnt];
                u2_in_north[l*16 +: 16] = tb[cnt][l];
            end
            @(negedge clk);
            if (u2_in_ready) cnt++;
            @(posedge clk);
            #1;
            guard++;
        end
        u2_in_valid = 1'b0;
        if (cnt < 2) fail_now("partial tile beats not accepted");
        rst = 1'b1;
        @(negedge clk);
        chk("mid-tile reset busy", u2_busy, 0);
        chk("mid-tile reset in_ready", u2_in_ready, 0);
        chk("mid-tile reset out_valid", u2_out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model(0);
        clear_model(1);
        @(negedge clk);
        chk("after reset in_ready", u2_in_ready, 1);
        chk("after reset out_valid", u2_out_valid, 0);
        @(posedge clk);
        #1;
        run2(1'b0, 1'b0, 0);

        // random tiles on the 2x2 block
        repeat (8) begin
            fill(int'($urandom_range(1, 2)), 16'h0);
            run2(1'($urandom_range(1)), 1'($urandom_range(1)), 0);
        end

        // 3x3 wrapping block: full-scale then random
        fill(0, 16'h7FFF);
        run3(1'b0, 1'b0);
        repeat (20) begin
            fill(int'($urandom_range(1, 2)), 16'h0);
            run3(1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        repeat (5) @(posedge clk);
        chk("scoreboard2 drained", exp2_q.size(), 0);
        chk("scoreboard3 drained", exp3_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
